joy_db9md_multi: RTL and testbench

- Parametrised successor to the two-port DB9 Mega Drive pad reader.
- Scans NUM_PORTS Sega 3/6-button pads over one shared 6-line DB9 input through an external port multiplexer.
- Drives the pad SELECT line and the port-select lines, then decodes the results into per-port 12-bit active-high button words.
- Reports pad presence and 6-button detection per port. Sits beside hps_io in the emu top; its outputs replace USB joystick words when SNAC is enabled.

---
 rtl/joy_db9md_multi.sv | 200 ++++++++++++++++++++
 tb/tb_joy_db9md_multi.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/joy_db9md_multi.sv
// Scans NUM_PORTS Sega 3/6-button pads through an external mux and decodes per-port button words.
// Latency: one full poll per update (two polls with DB9_DEBOUNCE_EN); outputs change atomically per port.
// Backpressure: none; free-running scanner paced by PHASE_CYCLES/POLL_CYCLES. Optional macro: DB9_DEBOUNCE_EN.
module joy_db9md_multi #(
    parameter int NUM_PORTS    = 2,
    parameter int PHASE_CYCLES = 480,
    parameter int POLL_CYCLES  = 96000,
    localparam int PSW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic [5:0]                joy_in,
    output logic                      joy_mdsel,
    output logic [PSW-1:0]            joy_port,
    output logic [12*NUM_PORTS-1:0]   joystick,
    output logic [NUM_PORTS-1:0]      present,
    output logic [NUM_PORTS-1:0]      six_btn,
    output logic                      scan_done
);

    localparam int CW  = $clog2(PHASE_CYCLES);
    localparam int PLW = $clog2(POLL_CYCLES);
    localparam logic [CW-1:0]  PH_LAST   = CW'(PHASE_CYCLES - 1);
    localparam logic [PLW-1:0] POLL_LAST = PLW'(POLL_CYCLES - 1);
    localparam logic [PSW-1:0] PORT_LAST = PSW'(NUM_PORTS - 1);

    // Phase states are consecutive so a phase advance is a simple +1.
    typedef enum logic [3:0] {
        ST_SETTLE = 4'd0,
        ST_PH0    = 4'd1, ST_PH1 = 4'd2, ST_PH2 = 4'd3, ST_PH3 = 4'd4,
        ST_PH4    = 4'd5, ST_PH5 = 4'd6, ST_PH6 = 4'd7, ST_PH7 = 4'd8,
        ST_NEXT   = 4'd9,
        ST_IDLE   = 4'd10
    } state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [PLW-1:0]            poll_q, poll_d;
    logic [PSW-1:0]            port_q, port_d;
    logic                      mdsel_q, mdsel_d;
    logic [5:0]                sync1_q, sync1_d;
    logic [5:0]                sync2_q, sync2_d;
    logic [11:0]               sh_btn_q, sh_btn_d;
    logic                      sh_pres_q, sh_pres_d;
    logic                      sh_six_q, sh_six_d;
    logic [12*NUM_PORTS-1:0]   joystick_q, joystick_d;
    logic [NUM_PORTS-1:0]      present_q, present_d;
    logic [NUM_PORTS-1:0]      six_q, six_d;
    logic                      done_q, done_d;
    logic [11:0]               raw_word;
    logic                      phase_end;
`ifdef DB9_DEBOUNCE_EN
    logic [12*NUM_PORTS-1:0]   prev_raw_q, prev_raw_d;
    logic [11:0]               agree;
`endif

    assign phase_end = (cnt_q == PH_LAST);

    // Next-state, shadow capture and per-port commit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        port_d    = port_q;
        sync1_d   = joy_in;
        sync2_d   = sync1_q;
        sh_btn_d  = sh_btn_q;
        sh_pres_d = sh_pres_q;
        sh_six_d  = sh_six_q;
        joystick_d = joystick_q;
        present_d = present_q;
        six_d     = six_q;
        done_d    = 1'b0;
        raw_word  = 12'h000;
        poll_d    = (poll_q == POLL_LAST) ? poll_q : poll_q + PLW'(1);
`ifdef DB9_DEBOUNCE_EN
        prev_raw_d = prev_raw_q;
        agree      = 12'h000;
`endif

        // SETTLE and the eight phases share one half-step timer.
        if (state_q != ST_NEXT && state_q != ST_IDLE) begin
            cnt_d = phase_end ? '0 : cnt_q + CW'(1);
            if (phase_end) begin
                state_d = state_t'(state_q + 4'd1);
            end
        end

        case (state_q)
            ST_SETTLE: begin
                sh_btn_d  = 12'h000;
                sh_pres_d = 1'b0;
                sh_six_d  = 1'b0;
            end
            ST_PH0: if (phase_end) begin
                // C, B, U, D, L, R
                sh_btn_d[5:0] = {~sync2_q[5], ~sync2_q[4], ~sync2_q[0],
                                 ~sync2_q[1], ~sync2_q[2], ~sync2_q[3]};
            end
            ST_PH1: if (phase_end) begin
                sh_btn_d[7:6] = {~sync2_q[5], ~sync2_q[4]};
                sh_pres_d     = ~sync2_q[2] & ~sync2_q[3];
            end
            ST_PH5: if (phase_end) begin
                sh_six_d = (sync2_q[3:0] == 4'h0);
            end
            ST_PH6: if (phase_end && sh_six_q) begin
                // Z, Y, X, Mode arrive on lines 0..3
                sh_btn_d[11:8] = {~sync2_q[0], ~sync2_q[1], ~sync2_q[2], ~sync2_q[3]};
            end
            ST_NEXT: begin
                raw_word = sh_pres_q ? (sh_six_q ? sh_btn_q : {4'h0, sh_btn_q[7:0]}) : 12'h000;
`ifdef DB9_DEBOUNCE_EN
                // A bit moves only when this scan agrees with the previous one.
                agree = ~(raw_word ^ prev_raw_q[12*port_q +: 12]);
                joystick_d[12*port_q +: 12] = (raw_word & agree) |
                                              (joystick_q[12*port_q +: 12] & ~agree);
                prev_raw_d[12*port_q +: 12] = raw_word;
`else
                joystick_d[12*port_q +: 12] = raw_word;
`endif
                present_d[port_q] = sh_pres_q;
                six_d[port_q]     = sh_pres_q & sh_six_q;
                cnt_d = '0;
                if (port_q == PORT_LAST) begin
                    port_d  = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    port_d  = port_q + PSW'(1);
                    state_d = ST_SETTLE;
                end
            end
            ST_IDLE: begin
                // cnt saturates so IDLE always spans at least one half-step with sel high.
                cnt_d = phase_end ? cnt_q : cnt_q + CW'(1);
                if (poll_q == POLL_LAST && phase_end) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                    poll_d  = '0;
                end
            end
            default: ;
        endcase

        // SELECT is low only in odd phases; registered so the pin is glitch-free.
        case (state_d)
            ST_PH1, ST_PH3, ST_PH5, ST_PH7: mdsel_d = 1'b0;
            default:                        mdsel_d = 1'b1;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= ST_SETTLE;
            cnt_q      <= '0;
            poll_q     <= '0;
            port_q     <= '0;
            mdsel_q    <= 1'b1;
            sync1_q    <= 6'h3F;
            sync2_q    <= 6'h3F;
            sh_btn_q   <= 12'h000;
            sh_pres_q  <= 1'b0;
            sh_six_q   <= 1'b0;
            joystick_q <= '0;
            present_q  <= '0;
            six_q      <= '0;
            done_q     <= 1'b0;
`ifdef DB9_DEBOUNCE_EN
            prev_raw_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            poll_q     <= poll_d;
            port_q     <= port_d;
            mdsel_q    <= mdsel_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sh_btn_q   <= sh_btn_d;
            sh_pres_q  <= sh_pres_d;
            sh_six_q   <= sh_six_d;
            joystick_q <= joystick_d;
            present_q  <= present_d;
            six_q      <= six_d;
            done_q     <= done_d;
`ifdef DB9_DEBOUNCE_EN
            prev_raw_q <= prev_raw_d;
`endif
        end
    end

    assign joy_mdsel = mdsel_q;
    assign joy_port  = port_q;
    assign joystick  = joystick_q;
    assign present   = present_q;
    assign six_btn   = six_q;
    assign scan_done = done_q;

endmodule

// File: tb/tb_joy_db9md_multi.sv
// Randomised scoreboard bench for joy_db9md_multi with behavioural Mega Drive pad models.
// Expected words come from a per-scan model of pad type and held buttons.
// Checks reset state, decoded words, presence, 6-button detection, timing and mid-scan reset.
module tb_joy_db9md_multi;

    localparam int NP   = 2;
    localparam int PC   = 4;
    localparam int POLL = 200;
    localparam int PSW  = 1;

    logic                 clk_sys = 1'b0;
    logic                 reset   = 1'b1;
    logic [5:0]           joy_in  = 6'h3F;
    logic                 joy_mdsel;
    logic [PSW-1:0]       joy_port;
    logic [12*NP-1:0]     joystick;
    logic [NP-1:0]        present;
    logic [NP-1:0]        six_btn;
    logic                 scan_done;

    always #5 clk_sys = ~clk_sys;

    joy_db9md_multi #(.NUM_PORTS(NP), .PHASE_CYCLES(PC), .POLL_CYCLES(POLL)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .joy_in    (joy_in),
        .joy_mdsel (joy_mdsel),
        .joy_port  (joy_port),
        .joystick  (joystick),
        .present   (present),
        .six_btn   (six_btn),
        .scan_done (scan_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- pad models (0 = nothing plugged, 1 = 3-button, 2 = 6-button)
    int          pad_type [NP];
    logic [11:0] pad_btn  [NP];
    int          pad_fc   [NP] = '{default: 0};
    int          pad_hi   [NP] = '{default: 100};
    logic        pad_prev [NP] = '{default: 1'b1};

    function automatic logic [5:0] pad_lines(input int t, input logic [11:0] b,
                                             input logic sel, input int fc);
        logic [5:0] l;
        if (t == 0) return 6'h3F;
        if (sel) begin
            if (t == 2 && fc == 3) l[3:0] = ~{b[8], b[9], b[10], b[11]};
            else                   l[3:0] = ~{b[0], b[1], b[2], b[3]};
            l[5:4] = ~{b[5], b[4]};
        end else begin
            l[1:0] = ~{b[2], b[3]};
            l[3:2] = 2'b00;
            if (t == 2 && fc == 3)      l[3:0] = 4'h0;
            else if (t == 2 && fc >= 4) l[3:0] = 4'hF;
            l[5:4] = ~{b[7], b[6]};
        end
        return l;
    endfunction

    // Each pad sees SELECT only while the mux routes to it; long high time resets a 6-button pad.
    always @(negedge clk_sys) begin
        logic s;
        for (int p = 0; p < NP; p++) begin
            s = (!$isunknown(joy_port) && int'(joy_port) == p) ? joy_mdsel : 1'b1;
            if (pad_prev[p] && !s) pad_fc[p]++;
            if (s) begin
                if (pad_hi[p] < 1000) pad_hi[p]++;
            end else pad_hi[p] = 0;
            if (pad_hi[p] >= 30) pad_fc[p] = 0;
            pad_prev[p] = s;
        end
        if ($isunknown(joy_port) || int'(joy_port) >= NP) joy_in = 6'h3F;
        else joy_in = pad_lines(pad_type[int'(joy_port)], pad_btn[int'(joy_port)], joy_mdsel,
                                pad_fc[int'(joy_port)]);
    end

    // ---------------- reference model and scoreboard queue
    typedef struct {
        logic [12*NP-1:0] joy;
        logic [NP-1:0]    pres;
        logic [NP-1:0]    six;
    } exp_t;
    exp_t exp_q[$];

    logic [11:0] m_out  [NP];
    logic [11:0] m_prev [NP];

    task automatic model_clear();
        for (int p = 0; p < NP; p++) begin
            m_out[p]  = 12'h000;
            m_prev[p] = 12'h000;
        end
    endtask

    task automatic model_push();
        exp_t e;
        logic [11:0] raw;
        for (int p = 0; p < NP; p++) begin
            case (pad_type[p])
                1:       raw = pad_btn[p] & 12'h0FF;
                2:       raw = pad_btn[p];
                default: raw = 12'h000;
            endcase
`ifdef DB9_DEBOUNCE_EN
            for (int b = 0; b < 12; b++)
                if (raw[b] == m_prev[p][b]) m_out[p][b] = raw[b];
            m_prev[p] = raw;
`else
            m_out[p] = raw;
`endif
            e.joy[12*p +: 12] = m_out[p];
            e.pres[p] = (pad_type[p] != 0);
            e.six[p]  = (pad_type[p] == 2);
        end
        exp_q.push_back(e);
    endtask

    task automatic apply(input int t0, input logic [11:0] b0, input int t1, input logic [11:0] b1);
        pad_type[0] = t0; pad_btn[0] = b0;
        pad_type[1] = t1; pad_btn[1] = b1;
        model_push();
    endtask

    function automatic logic [11:0] rand_btn();
        logic [11:0] b;
        b = 12'($urandom);
        if (b[2] && b[3]) b[2] = 1'b0;   // up and down cannot both be pressed
        return b;
    endfunction

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!scan_done && n < 500);
        if (!scan_done) begin
            checks++; errors++;
            $display("FAIL scan_done_timeout actual=0 required=1 within 500 cycles");
        end
    endtask

    // ---------------- monitor: scoreboard pops plus SELECT and port timing
    int cyc = 0;
    always @(posedge clk_sys) cyc++;

    int last_done = -1;
    int low_run   = 0;
    int prev_port = 0;

    always @(negedge clk_sys) begin
        exp_t e;
        if (reset) begin
            last_done = -1;
            low_run   = 0;
            prev_port = 0;
        end else begin
            if (!joy_mdsel) low_run++;
            else if (low_run != 0) begin
                chk("sel_low_len", low_run, PC);
                low_run = 0;
            end
            if (int'(joy_port) != prev_port) begin
                chk("port_step", 32'(joy_port), (prev_port + 1) % NP);
                prev_port = int'(joy_port);
            end
            if (scan_done) begin
                if (last_done >= 0) chk("scan_period", cyc - last_done, POLL);
                last_done = cyc;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_scan_done actual=pulse required=none queued");
                end else begin
                    e = exp_q.pop_front();
                    for (int p = 0; p < NP; p++) begin
                        chk($sformatf("joystick_p%0d", p), 32'(joystick[12*p +: 12]), 32'(e.joy[12*p +: 12]));
                        chk($sformatf("present_p%0d", p), 32'(present[p]), 32'(e.pres[p]));
                        chk($sformatf("six_btn_p%0d", p), 32'(six_btn[p]), 32'(e.six[p]));
                    end
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_joystick"},  32'(joystick),  0);
        chk({tag, "_present"},   32'(present),   0);
        chk({tag, "_six_btn"},   32'(six_btn),   0);
        chk({tag, "_scan_done"}, 32'(scan_done), 0);
        chk({tag, "_mdsel"},     32'(joy_mdsel), 1);
        chk({tag, "_port"},      32'(joy_port),  0);
    endtask

    // Reset during PHASE3 of port 1 (second low SELECT pulse on that port).
    task automatic reset_mid_scan();
        int   falls = 0;
        int   n     = 0;
        logic ps    = 1'b1;
        do begin
            @(negedge clk_sys);
            n++;
            if (int'(joy_port) == 1 && ps && !joy_mdsel) falls++;
            ps = joy_mdsel;
        end while (falls < 2 && n < 500);
        if (falls < 2) begin
            checks++; errors++;
            $display("FAIL phase3_timeout actual=%0d required=2 low pulses on port 1", falls);
        end
        reset = 1'b1;
        @(posedge clk_sys);
        #1;
        check_reset_state("midreset");
        repeat (40) @(negedge clk_sys);
        exp_q.delete();
        model_clear();
        model_push();
        reset = 1'b0;
    endtask

    // ---------------- stimulus
    initial begin
        for (int p = 0; p < NP; p++) begin
            pad_type[p] = 0;
            pad_btn[p]  = 12'h000;
        end
        model_clear();
        reset = 1'b1;
        apply(1, 12'h011, 0, 12'h000);             // 3-button B+Right on port 0, port 1 floating
        repeat (3) @(negedge clk_sys);
        check_reset_state("reset");
        reset = 1'b0;

        wait_done(); apply(1, 12'h011, 2, 12'h980); // 6-button Start+Z+Mode on port 1
        wait_done(); apply(0, 12'h000, 2, 12'h980); // unplug port 0
        wait_done(); apply(1, 12'h040, 2, 12'h000); // A for one scan
        wait_done(); apply(1, 12'h000, 1, 12'h000);
        wait_done(); apply(1, 12'h040, 1, 12'h000); // A held for two scans
        wait_done(); apply(1, 12'h040, 1, 12'h000);
        wait_done(); apply(int'($urandom_range(1, 2)), rand_btn(), 2, rand_btn());
        reset_mid_scan();

        for (int i = 0; i < 16; i++) begin
            wait_done();
            apply(int'($urandom_range(0, 2)), rand_btn(), int'($urandom_range(0, 2)), rand_btn());
        end
        wait_done();
        repeat (2) @(negedge clk_sys);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
